// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller (master) and the datapath/memory/debug side (slave).
// A memory access is in flight while MemRead or MemWrite is high; mem_ready high in such a cycle completes it.
interface multicycle_control_if #(
    parameter int ICNT_W = 16
);
    logic [5:0]        opcode;
    logic              mem_ready;
    logic              PCWrite;
    logic              PCWriteCond;
    logic              IorD;
    logic              MemRead;
    logic              MemWrite;
    logic              MemtoReg;
    logic              IRWrite;
    logic              ALUSrcA;
    logic              RegWrite;
    logic              RegDst;
    logic [1:0]        PCSource;
    logic [1:0]        ALUSrcB;
    logic [1:0]        ALUOp;
    logic [3:0]        state;
    logic              illegal_op;
    logic [ICNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               state, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               state, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset with a retired-instruction counter.
// Define MC_CTRL_ADDI_EN to add the ADDIEX/ADDIWB path for addi.
module multicycle_control #(
    parameter int ICNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t            state_q, state_d;
    logic [ICNT_W-1:0] count_q, count_d;
    logic              retire;
    logic              illegal;

    logic pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg;
    logic ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source, alu_src_b, alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state, retire detection and illegal-opcode flag.
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQ;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:       state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  retire = 1'b1;
            S_MEMWR: begin
                state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
                retire  = bus.mem_ready;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    retire = 1'b1;
            S_BEQ:    retire = 1'b1;
            S_JUMP:   retire = 1'b1;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: retire = 1'b1;
`endif
            default:  state_d = S_FETCH;
        endcase
        count_d = retire ? count_q + ICNT_W'(1) : count_q;
    end

    // Moore control decode; only FETCH looks at mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held, independent of the clock.
    assign bus.PCWrite     = pc_write & ~reset;
    assign bus.PCWriteCond = pc_write_cond & ~reset;
    assign bus.MemRead     = mem_read & ~reset;
    assign bus.MemWrite    = mem_write & ~reset;
    assign bus.IRWrite     = ir_write & ~reset;
    assign bus.RegWrite    = reg_write & ~reset;
    assign bus.IorD        = ior_d;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.RegDst      = reg_dst;
    assign bus.PCSource    = pc_source;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.state       = state_q;
    assign bus.illegal_op  = illegal & ~reset;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: cycle-vector table plus reset-in-wait and counter-wrap sequences.
module tb_multicycle_control;

    localparam int ICNT_W = 4;

    // Control word bit order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA RegWrite RegDst PCSource ALUSrcB ALUOp
    localparam logic [15:0] C_FW     = 16'b0_0_0_1_0_0_0_0_0_0_00_01_00;
    localparam logic [15:0] C_FR     = 16'b1_0_0_1_0_0_1_0_0_0_00_01_00;
    localparam logic [15:0] C_DEC    = 16'b0_0_0_0_0_0_0_0_0_0_00_11_00;
    localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
    localparam logic [15:0] C_MEMRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_0_1_0_0_1_0_00_00_00;
    localparam logic [15:0] C_MEMWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_EXEC   = 16'b0_0_0_0_0_0_0_1_0_0_00_00_10;
    localparam logic [15:0] C_RWB    = 16'b0_0_0_0_0_0_0_0_1_1_00_00_00;
    localparam logic [15:0] C_BEQ    = 16'b0_1_0_0_0_0_0_1_0_0_01_00_01;
    localparam logic [15:0] C_JUMP   = 16'b1_0_0_0_0_0_0_0_0_0_10_00_00;
    localparam logic [15:0] C_ADDIEX = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
    localparam logic [15:0] C_ADDIWB = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
    localparam logic [15:0] STROBES  = 16'b1_1_0_1_1_0_1_0_1_0_00_00_00;

    typedef struct packed {
        logic [3:0]        st;
        logic [15:0]       ctrl;
        logic              ill;
        logic [ICNT_W-1:0] cnt;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    typedef struct {
        logic [5:0]        op;
        logic              mr;
        logic [3:0]        st;
        logic [15:0]       ctrl;
        logic              ill;
        logic [ICNT_W-1:0] cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] msk_q[$];
    vec_t             tbl[$];

    multicycle_control_if #(.ICNT_W(ICNT_W)) bus ();

    multicycle_control #(.ICNT_W(ICNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    function automatic obs_t actual();
        obs_t a;
        a.st   = bus.state;
        a.ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                  bus.PCSource, bus.ALUSrcB, bus.ALUOp};
        a.ill  = bus.illegal_op;
        a.cnt  = bus.instr_count;
        return a;
    endfunction

    task automatic check(input string name);
        obs_t a, e, m;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        a = actual();
        e = obs_t'(exp_q.pop_front());
        m = obs_t'(msk_q.pop_front());
        if ((a & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ctrl=%b ill=%b cnt=%0d, want st=%0d ctrl=%b ill=%b cnt=%0d (mask ctrl=%b)",
                     name, a.st, a.ctrl, a.ill, a.cnt, e.st, e.ctrl, e.ill, e.cnt, m.ctrl);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic [5:0] op, input logic mr, input logic [3:0] st,
                         input logic [15:0] ctrl, input logic ill,
                         input logic [ICNT_W-1:0] cnt, input string name);
        obs_t e;
        bus.opcode    = op;
        bus.mem_ready = mr;
        e = '{st: st, ctrl: ctrl, ill: ill, cnt: cnt};
        exp_q.push_back(e);
        msk_q.push_back('1);
        #1;
        check(name);
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [15:0] ctrl, input logic ill, input int cnt);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctrl = ctrl; v.ill = ill; v.cnt = ICNT_W'(cnt);
        tbl.push_back(v);
    endtask

    task automatic check_reset(input string name);
        obs_t e, m;
        e = '{st: 4'd0, ctrl: 16'd0, ill: 1'b0, cnt: '0};
        m = '{st: 4'hF, ctrl: STROBES, ill: 1'b1, cnt: '1};
        exp_q.push_back(e);
        msk_q.push_back(m);
        check(name);
    endtask

    // ---------------- test ----------------
    initial begin
        int end_cnt;
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b0;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b1;

        // R-type
        add(6'h00, 1, 0, C_FR, 0, 0);
        add(6'h00, 1, 1, C_DEC, 0, 0);
        add(6'h00, 1, 6, C_EXEC, 0, 0);
        add(6'h00, 1, 7, C_RWB, 0, 0);
        // lw with three wait cycles in MEMRD
        add(6'h23, 1, 0, C_FR, 0, 1);
        add(6'h23, 0, 1, C_DEC, 0, 1);
        add(6'h23, 1, 2, C_MEMADR, 0, 1);
        add(6'h23, 0, 3, C_MEMRD, 0, 1);
        add(6'h23, 0, 3, C_MEMRD, 0, 1);
        add(6'h23, 0, 3, C_MEMRD, 0, 1);
        add(6'h23, 1, 3, C_MEMRD, 0, 1);
        add(6'h23, 1, 4, C_MEMWB, 0, 1);
        // sw with a fetch wait and one MEMWR wait
        add(6'h2B, 0, 0, C_FW, 0, 2);
        add(6'h2B, 1, 0, C_FR, 0, 2);
        add(6'h2B, 1, 1, C_DEC, 0, 2);
        add(6'h2B, 0, 2, C_MEMADR, 0, 2);
        add(6'h2B, 0, 5, C_MEMWR, 0, 2);
        add(6'h2B, 1, 5, C_MEMWR, 0, 2);
        // beq, j
        add(6'h04, 1, 0, C_FR, 0, 3);
        add(6'h04, 1, 1, C_DEC, 0, 3);
        add(6'h04, 1, 8, C_BEQ, 0, 3);
        add(6'h02, 1, 0, C_FR, 0, 4);
        add(6'h02, 0, 1, C_DEC, 0, 4);
        add(6'h02, 1, 9, C_JUMP, 0, 4);
        // unsupported opcode
        add(6'h3F, 1, 0, C_FR, 0, 5);
        add(6'h3F, 1, 1, C_DEC, 1, 5);
        // addi
        add(6'h08, 1, 0, C_FR, 0, 5);
`ifdef MC_CTRL_ADDI_EN
        add(6'h08, 1, 1, C_DEC, 0, 5);
        add(6'h08, 1, 10, C_ADDIEX, 0, 5);
        add(6'h08, 1, 11, C_ADDIWB, 0, 5);
        end_cnt = 6;
`else
        add(6'h08, 1, 1, C_DEC, 1, 5);
        end_cnt = 5;
`endif
        add(6'h02, 0, 0, C_FW, 0, end_cnt);

        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #1 check_reset("reset_initial");
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].ctrl, tbl[i].ill, tbl[i].cnt,
                  $sformatf("row%0d", i));
        end

        // Reset while lw waits in MEMRD: takes effect with no clock edge, instruction not counted
        @(negedge clk); apply(6'h23, 1, 0, C_FR, 0, ICNT_W'(end_cnt), "rst_lw_fetch");
        @(negedge clk); apply(6'h23, 1, 1, C_DEC, 0, ICNT_W'(end_cnt), "rst_lw_decode");
        @(negedge clk); apply(6'h23, 1, 2, C_MEMADR, 0, ICNT_W'(end_cnt), "rst_lw_memadr");
        @(negedge clk); apply(6'h23, 0, 3, C_MEMRD, 0, ICNT_W'(end_cnt), "rst_lw_memrd_wait");
        #1 reset = 1'b1;
        #1 check_reset("reset_in_memrd_wait");
        @(negedge clk);
        reset = 1'b0;
        apply(6'h02, 0, 0, C_FW, 0, '0, "post_reset_fetch");

        // Sixteen jumps wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); apply(6'h02, 1, 0, C_FR, 0, ICNT_W'(i), $sformatf("wrap_fetch%0d", i));
            @(negedge clk); apply(6'h02, 1, 1, C_DEC, 0, ICNT_W'(i), $sformatf("wrap_decode%0d", i));
            @(negedge clk); apply(6'h02, 1, 9, C_JUMP, 0, ICNT_W'(i), $sformatf("wrap_jump%0d", i));
        end
        @(negedge clk); apply(6'h02, 0, 0, C_FW, 0, '0, "wrap_to_zero");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the parameter ICNT_W, default 16, setting the width of the retired-instruction counter.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 The block SHALL have the port mem_ready, input, 1 bit: memory has completed the current read or write this cycle.
REQ-006 The block SHALL have the outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite and RegDst, each 1 bit: standard multicycle datapath controls.
REQ-007 The block SHALL have the outputs PCSource, ALUSrcB and ALUOp, each 2 bits; ALUOp drives ALU_Control (00 add, 01 sub, 10 use funct).
REQ-008 The block SHALL have the output state, 4 bits: current FSM state, for debug.
REQ-009 The block SHALL have the output illegal_op, 1 bit: the DECODE state saw an unsupported opcode.
REQ-010 The block SHALL have the output instr_count, ICNT_W bits: the number of retired instructions.

Function
REQ-011 The Moore FSM SHALL use this state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-012 In FETCH the block SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; it SHALL drive IRWrite=1 and PCWrite=1 only when mem_ready=1, and SHALL stay in FETCH while mem_ready=0.
REQ-013 In DECODE the block SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00, then branch on opcode: 000000 to EXEC, 100011 or 101011 to MEMADR, 000100 to BEQ, 000010 to JUMP, 001000 to ADDIEX; any other opcode SHALL go to FETCH.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to MEMRD for opcode 100011 or MEMWR otherwise.
REQ-015 MEMRD SHALL drive MemRead=1 and IorD=1, and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1 and IorD=1, and SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to RWB.
REQ-019 RWB SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0, then go to FETCH.
REQ-020 BEQ SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01, then go to FETCH.
REQ-021 JUMP SHALL drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-022 Every control not listed for a state SHALL be 0; outputs SHALL decode from the state register only, except the mem_ready gating in REQ-012.
REQ-023 illegal_op SHALL be 1 for exactly the DECODE cycle that holds an unsupported opcode.
REQ-024 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR (on completion), RWB, BEQ, JUMP or ADDIWB; it SHALL not increment on an illegal-opcode return, and SHALL wrap from all-ones to 0.
REQ-025 A memory wait SHALL have no timeout; mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.

Reset
REQ-026 While reset=1 the block SHALL immediately, without waiting for clk, force state=FETCH, instr_count=0, illegal_op=0 and all write/read strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) to 0.
REQ-027 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction without counting it.
REQ-028 After reset deasserts, FETCH outputs SHALL appear per REQ-012.

Configuration
REQ-029 With the macro MC_CTRL_ADDI_EN defined, ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00, then to ADDIWB) and ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0, then to FETCH) SHALL exist.
REQ-030 Without MC_CTRL_ADDI_EN, opcode 001000 SHALL be treated as illegal per REQ-013 and REQ-023, and codes 10-11 SHALL behave as in REQ-011.

Verification
REQ-031 The bench SHALL cover: R-type (opcode 000000, mem_ready=1) -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1 in RWB; instr_count 0 to 1.
REQ-032 The bench SHALL cover: lw (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1 and IorD=1; then MEMWB with MemtoReg=1; count +1.
REQ-033 The bench SHALL cover: sw (101011), then beq (000100), then j (000010) -> MemWrite pulse in MEMWR; PCWriteCond=1 and ALUOp=01 in BEQ; PCWrite=1 and PCSource=10 in JUMP; count +3.
REQ-034 The bench SHALL cover: opcode 111111 -> illegal_op=1 for one cycle in DECODE; return to FETCH; count unchanged.
REQ-035 The bench SHALL cover: reset asserted during a MEMRD wait -> state=0 and strobes 0 without a clk edge; count=0.
REQ-036 The bench SHALL cover: addi (001000) with and without MC_CTRL_ADDI_EN -> states 0,1,10,11,0 with count +1; or illegal_op=1 with no count.
